// File: rtl/ppu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a shared combinational posit datapath.
// Holds operands stable for a fixed multicycle window, then presents the result until accepted.
module ppu_issue_arbiter #(
   parameter int N           = 16,
   parameter int ES          = 1,
   parameter int OP_SIZE     = 3,
   parameter int EXEC_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [N-1:0]       req0_p1,
   input  logic [N-1:0]       req0_p2,
   input  logic [OP_SIZE-1:0] req0_op,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [N-1:0]       req1_p1,
   input  logic [N-1:0]       req1_p2,
   input  logic [OP_SIZE-1:0] req1_op,
   output logic [N-1:0]       dp_p1,
   output logic [N-1:0]       dp_p2,
   output logic [OP_SIZE-1:0] dp_op,
   input  logic [N-1:0]       dp_pout,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [N-1:0]       resp_pout,
   output logic               resp_id,
   output logic               busy
);

   if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15 || ES < 0 || ES >= N) begin : g_bad_param
      $error("ppu_issue_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       last_grant;
   logic       grant_id;
   logic       accept;

   // A lone requester always wins; on a tie the one not served last time wins.
   always_comb begin
      grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      accept     = (state == IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !grant_id;
      req1_ready = accept && grant_id;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         resp_valid <= 1'b0;
         resp_pout  <= '0;
         resp_id    <= 1'b0;
         dp_p1      <= '0;
         dp_p2      <= '0;
         dp_op      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dp_p1      <= grant_id ? req1_p1 : req0_p1;
                  dp_p2      <= grant_id ? req1_p2 : req0_p2;
                  dp_op      <= grant_id ? req1_op : req0_op;
                  resp_id    <= grant_id;
                  last_grant <= grant_id;
                  cnt        <= CNT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_pout  <= dp_pout;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_issue_arbiter.sv
// Scoreboard bench for ppu_issue_arbiter: a cycle-level arbitration model predicts grants and
// responses, a negedge monitor checks every presented response; extra instances cover latency 1 and 15.
module tb_ppu_issue_arbiter;

   localparam int E = 2;
   localparam logic [2:0] MUL = 3'd2;
   localparam int NEVER = 1 << 30;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0v, r1v, r0r, r1r, rr;
   logic [15:0] a0, b0, a1, b1;
   logic [2:0]  o0, o1;
   logic [15:0] dp_p1, dp_p2, dp_pout, resp_pout;
   logic [2:0]  dp_op;
   logic        resp_valid, resp_id, busy;

   // latency-boundary instances
   logic        xv;
   logic [15:0] xa, xb;
   logic [2:0]  xo;
   logic        ar0, ar1, ab, av, aid, br0, br1, bb, bv, bid;
   logic [15:0] ap1, ap2, apo, arp, bp1, bp2, bpo, brp;
   logic [2:0]  aop, bop;

   always #5 clk = ~clk;

   // Stand-in datapath: asymmetric so operand swaps show; MUL by 1.0 returns the other operand.
   function automatic logic [15:0] fdp(logic [15:0] p, logic [15:0] q, logic [2:0] op);
      if (op == MUL && p == 16'h4000) return q;
      return (p ^ {q[7:0], q[15:8]}) + {13'd0, op};
   endfunction

   assign dp_pout = fdp(dp_p1, dp_p2, dp_op);
   assign apo     = fdp(ap1, ap2, aop);
   assign bpo     = fdp(bp1, bp2, bop);

   ppu_issue_arbiter #(.N(16), .ES(1), .OP_SIZE(3), .EXEC_CYCLES(E)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req0_ready(r0r), .req0_p1(a0), .req0_p2(b0), .req0_op(o0),
      .req1_valid(r1v), .req1_ready(r1r), .req1_p1(a1), .req1_p2(b1), .req1_op(o1),
      .dp_p1(dp_p1), .dp_p2(dp_p2), .dp_op(dp_op), .dp_pout(dp_pout),
      .resp_valid(resp_valid), .resp_ready(rr), .resp_pout(resp_pout), .resp_id(resp_id),
      .busy(busy));

   ppu_issue_arbiter #(.N(16), .ES(1), .OP_SIZE(3), .EXEC_CYCLES(1)) dut_e1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(xv), .req0_ready(ar0), .req0_p1(xa), .req0_p2(xb), .req0_op(xo),
      .req1_valid(1'b0), .req1_ready(ar1), .req1_p1(16'h0), .req1_p2(16'h0), .req1_op(3'd0),
      .dp_p1(ap1), .dp_p2(ap2), .dp_op(aop), .dp_pout(apo),
      .resp_valid(av), .resp_ready(1'b1), .resp_pout(arp), .resp_id(aid), .busy(ab));

   ppu_issue_arbiter #(.N(16), .ES(1), .OP_SIZE(3), .EXEC_CYCLES(15)) dut_e15 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(xv), .req0_ready(br0), .req0_p1(xa), .req0_p2(xb), .req0_op(xo),
      .req1_valid(1'b0), .req1_ready(br1), .req1_p1(16'h0), .req1_p2(16'h0), .req1_op(3'd0),
      .dp_p1(bp1), .dp_p2(bp2), .dp_op(bop), .dp_pout(bpo),
      .resp_valid(bv), .resp_ready(1'b1), .resp_pout(brp), .resp_id(bid), .busy(bb));

   typedef struct {
      logic [15:0] pout;
      logic        id;
      logic [15:0] p1;
      logic [15:0] p2;
      logic [2:0]  op;
      int          rise;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    passes = 0;
   int    edges  = 0;

   // reference model state
   logic  m_last    = 1'b1;
   logic  m_pending = 1'b0;
   int    m_rise    = 0;
   int    free_at   = 0;

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Drive one cycle of requester/response inputs, predict the outcome of the next edge.
   task automatic cycle(input logic v0, input logic v1, input logic [15:0] p0, input logic [15:0] q0,
                        input logic [15:0] p1, input logic [15:0] q1, input logic [2:0] c0,
                        input logic [2:0] c1, input logic r);
      int    e;
      logic  acc, g;
      item_t it;
      r0v = v0; r1v = v1; a0 = p0; b0 = q0; a1 = p1; b1 = q1; o0 = c0; o1 = c1; rr = r;
      @(negedge clk);
      e   = edges + 1;
      acc = !m_pending && (e >= free_at) && (v0 || v1);
      g   = (v0 && v1) ? !m_last : v1;
      chk("ready0", r0r, acc && !g);
      chk("ready1", r1r, acc && g);
      if (m_pending && r && e >= m_rise + 1) begin
         m_pending = 1'b0;
         free_at   = e + 1;
      end
      if (acc) begin
         it.id   = g;
         it.p1   = g ? p1 : p0;
         it.p2   = g ? q1 : q0;
         it.op   = g ? c1 : c0;
         it.pout = fdp(it.p1, it.p2, it.op);
         it.rise = e + E;
         sb.push_back(it);
         m_last    = g;
         m_pending = 1'b1;
         m_rise    = e + E;
         free_at   = NEVER;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic r);
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, r);
   endtask

   task automatic rand_cycle(input int rr_bias);
      cycle(($urandom % 3) != 0, ($urandom % 3) != 0, 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), ($urandom % 4) < rr_bias);
   endtask

   // Response monitor
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", resp_valid, 1'b0);
         end else begin
            if (!prev_valid) chk("latency", edges, sb[0].rise);
            chk("resp_pout", resp_pout, sb[0].pout);
            chk("resp_id", resp_id, sb[0].id);
            chk("dp_p1_hold", dp_p1, sb[0].p1);
            chk("dp_p2_hold", dp_p2, sb[0].p2);
            chk("dp_op_hold", dp_op, sb[0].op);
            chk("busy_resp", busy, 1'b1);
            chk("ready_in_resp", {r0r, r1r}, 2'b00);
            if (rr) void'(sb.pop_front());
         end
      end
      prev_valid <= rst_n && resp_valid;
   end

   initial begin
      int la, lb;
      rst_n = 1'b0; rr = 1'b0; xv = 1'b0; xa = 16'h0; xb = 16'h0; xo = 3'd0;
      r0v = 1'b0; r1v = 1'b0; a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0; o0 = 3'd0; o1 = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_outputs", {resp_pout, resp_id, dp_p1, dp_p2, dp_op, busy}, 0);
      chk("rst_ready", {r0r, r1r}, 2'b00);
      rst_n = 1'b1;

      // single MUL on requester 0, accepted on the first edge after reset release
      cycle(1'b1, 1'b0, 16'h4000, 16'h4800, 16'h0, 16'h0, MUL, 3'd0, 1'b1);
      chk("dp_op_mul", dp_op, MUL);
      chk("busy_exec", busy, 1'b1);
      for (int i = 0; i < 6; i++) idle_cycle(1'b1);
      chk("mul_result", resp_pout, 16'h4800);

      // both requesters saturating, response always accepted
      for (int i = 0; i < 24; i++)
         cycle(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               3'($urandom), 3'($urandom), 1'b1);

      // backpressure: hold resp_ready low while requesters keep asking
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 3'd1, 3'd5, 1'b0);
      for (int i = 0; i < 4; i++) idle_cycle(1'b1);

      // random traffic with varied backpressure
      for (int i = 0; i < 1500; i++) rand_cycle(1 + (i / 500));

      // drain, then a reset pulse in the middle of an execution
      for (int i = 0; i < 40 && m_pending; i++) idle_cycle(1'b1);
      chk("drain_before_reset", m_pending, 1'b0);
      cycle(1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd3, 3'd4, 1'b1);
      r0v = 1'b0; r1v = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midexec_rst_valid", resp_valid, 1'b0);
      chk("midexec_rst_outputs", {resp_pout, resp_id, dp_p1, dp_p2, dp_op, busy}, 0);
      chk("midexec_rst_ready", {r0r, r1r}, 2'b00);
      sb.delete();
      m_pending = 1'b0; m_last = 1'b1; free_at = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle(1'b1, 1'b1, 16'h0abc, 16'h0def, 16'h7777, 16'h8888, 3'd6, 3'd7, 1'b1);
      chk("post_rst_tie_id", dut.resp_id, 1'b0);
      for (int i = 0; i < 40 && (m_pending || sb.size() != 0); i++) idle_cycle(1'b1);
      chk("drain_final", sb.size(), 0);

      // latency boundaries on the EXEC_CYCLES=1 and =15 instances
      la = -1; lb = -1;
      xv = 1'b1; xa = 16'h3c5a; xb = 16'h0f0f; xo = 3'd6;
      @(negedge clk);
      chk("x_ready", {ar0, br0}, 2'b11);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) xv = 1'b0;
         if (av && la < 0) begin
            la = k;
            chk("e1_pout", arp, fdp(16'h3c5a, 16'h0f0f, 3'd6));
         end
         if (bv && lb < 0) begin
            lb = k;
            chk("e15_pout", brp, fdp(16'h3c5a, 16'h0f0f, 3'd6));
            chk("e15_id", bid, 1'b0);
         end
      end
      chk("e1_latency", la, 1);
      chk("e15_latency", lb, 15);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ppu_issue_arbiter.md
PPU_ISSUE_ARBITER -- requirements
Module: ppu_issue_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, posit width.
REQ-002 SHALL have parameter ES, default 1, exponent field width; passed through for documentation and bench pairing only.
REQ-003 SHALL have parameter OP_SIZE, default 3, opcode width, matching the shared datapath.
REQ-004 SHALL have parameter EXEC_CYCLES, default 2, legal 1..15, the multicycle allowance for the combinational datapath.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports req0_valid (input, 1) and req1_valid (input, 1), requester operation valid.
REQ-008 SHALL have ports req0_ready (output, 1) and req1_ready (output, 1), grant/accept to requester.
REQ-009 SHALL have ports req0_p1, req0_p2, req1_p1, req1_p2 (input, N), operand posits.
REQ-010 SHALL have ports req0_op and req1_op (input, OP_SIZE), opcodes.
REQ-011 SHALL have ports dp_p1 and dp_p2 (output, N) and dp_op (output, OP_SIZE), registered drive to the shared posit datapath.
REQ-012 SHALL have port dp_pout, input, N, datapath result.
REQ-013 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_pout (output, N) and resp_id (output, 1, requester index).
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-016 In IDLE, SHALL assert req_ready only to the granted requester, combinationally, and deassert both ready outputs in EXEC and RESP.
REQ-017 Grant rule: if only one valid, grant it; if both valid, grant the requester not recorded in last_grant (round-robin).
REQ-018 On an acceptance edge (valid&&ready), SHALL register operands and op into dp_p1/dp_p2/dp_op, record resp_id and last_grant, load cnt=EXEC_CYCLES-1, and enter EXEC.
REQ-019 dp_p1/dp_p2/dp_op SHALL change only on acceptance and hold stable through EXEC and RESP.
REQ-020 In EXEC with cnt!=0, SHALL decrement cnt each cycle; with cnt==0, SHALL capture dp_pout into resp_pout and enter RESP.
REQ-021 Latency: resp_valid SHALL rise exactly EXEC_CYCLES cycles after the acceptance edge.
REQ-022 In RESP, resp_valid SHALL be held high, with resp_pout/resp_id stable, until resp_valid&&resp_ready; on that edge it SHALL return to IDLE.
REQ-023 No acceptance SHALL occur in the cycle of the response handshake; the next accept is earliest in the following IDLE cycle (max throughput 1 op per EXEC_CYCLES+2 cycles).
REQ-024 A requester deasserting valid in IDLE before grant SHALL not be recorded; last_grant changes only on acceptance.
REQ-025 resp_ready while not in RESP SHALL be ignored.
REQ-026 The opcode SHALL not be decoded; all ops, including special/trivial cases, SHALL take the same EXEC_CYCLES latency.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, cnt=0, last_grant=1 (requester 0 wins the first tie), resp_valid=0, resp_pout=0, resp_id=0, dp_p1=0, dp_p2=0, dp_op=0, busy=0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response produced.
REQ-029 After deassertion, the first rising edge SHALL be able to accept a request.

Verification
REQ-030 Single op, EXEC_CYCLES=2, P16E1: req0 MUL p1=0x4000 p2=0x4800 -> dp_op=MUL, resp_valid 2 cycles after accept, resp_pout=0x4800, resp_id=0.
REQ-031 Both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 with resp_id sequence matching; ops spaced EXEC_CYCLES+2 cycles apart.
REQ-032 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_pout/resp_id stable, both req_ready=0, dp_* unchanged; release -> IDLE next cycle.
REQ-033 rst_n pulsed low mid-EXEC -> all outputs at reset values immediately, no resp_valid afterward; next tie grants requester 0.
REQ-034 EXEC_CYCLES=1 boundary: accept at edge t -> resp_valid at edge t+1 with correct result; EXEC_CYCLES=15 -> resp_valid at edge t+15.
REQ-035 Requester drops valid before grant (in a non-IDLE state) -> never accepted, last_grant unchanged.
